// File: rtl/generador_mdio.sv
// MDIO station-management transmitter.
// Generates MDC at CLK/2 while a transaction runs and shifts out an optional
// preamble followed by a 32-bit management frame. On read frames it releases
// the line from the turnaround onward and captures the 16 returned data bits.
module generador_mdio #(
  parameter int PREAMBLE = 32
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE);

  state_t      state_q, state_d;
  // phase_q = 1 while the current slot's high phase is running (or before the first slot),
  // so the next edge presents a new bit with MDC low.
  logic        phase_q, phase_d;
  // PRE: preamble slots still to present. FRAME: index of the bit on the line,
  // 32 meaning no frame bit presented yet.
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] frame_q, frame_d;
  logic        rd_mode_q, rd_mode_d;
  logic        mdc_d, out_d, oe_d, rdy_d, busy_d;
  logic [15:0] rd_data_d;

  logic [4:0]  next_idx;
  logic        next_oe;

  // Bit that the next low phase will present, and whether the STA owns the line for it.
  assign next_idx = 5'(cnt_q - 6'd1);
  assign next_oe  = !rd_mode_q || (next_idx >= 5'd18);

  // Next-state and next-output logic; all outputs are registered below so MDC is glitch-free.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    rd_mode_d = rd_mode_q;
    mdc_d     = MDC;
    out_d     = MDIO_OUT;
    oe_d      = MDIO_OE;
    rd_data_d = RD_DATA;
    rdy_d     = 1'b0;
    busy_d    = BUSY;

    case (state_q)
      IDLE: begin
        mdc_d  = 1'b0;
        out_d  = 1'b0;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        if (MDIO_START) begin
          frame_d   = T_DATA;
          rd_mode_d = (T_DATA[29:28] == 2'b10);
          busy_d    = 1'b1;
          phase_d   = 1'b1;
          if (PREAMBLE == 0) begin
            state_d = FRAME;
            cnt_d   = 6'd32;
          end else begin
            state_d = PRE;
            cnt_d   = PRE_LEN;
          end
        end
      end

      PRE: begin
        if (phase_q) begin
          mdc_d   = 1'b0;
          out_d   = 1'b1;
          oe_d    = 1'b1;
          phase_d = 1'b0;
          cnt_d   = cnt_q - 6'd1;
        end else begin
          mdc_d   = 1'b1;
          phase_d = 1'b1;
          // Last preamble slot is on the line: frame bits follow from the next low phase.
          if (cnt_q == 6'd0) begin
            state_d = FRAME;
            cnt_d   = 6'd32;
          end
        end
      end

      FRAME: begin
        if (phase_q) begin
          // This edge ends the high phase of bit cnt_q, so the PHY's data bit is valid here.
          if (rd_mode_q && (cnt_q <= 6'd15)) begin
            rd_data_d = {RD_DATA[14:0], MDIO_IN};
          end
          mdc_d = 1'b0;
          if (cnt_q == 6'd0) begin
            state_d = DONE;
            out_d   = 1'b0;
            oe_d    = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            out_d   = next_oe & frame_q[next_idx];
            oe_d    = next_oe;
            phase_d = 1'b0;
            cnt_d   = cnt_q - 6'd1;
          end
        end else begin
          mdc_d   = 1'b1;
          phase_d = 1'b1;
        end
      end

      DONE: begin
        // START is deliberately not looked at here; the first IDLE cycle accepts it.
        state_d = IDLE;
        busy_d  = 1'b0;
        mdc_d   = 1'b0;
        out_d   = 1'b0;
        oe_d    = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial transaction, including captured data.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= 6'd0;
      frame_q   <= 32'h0;
      rd_mode_q <= 1'b0;
      MDC       <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      RD_DATA   <= 16'h0000;
      DATA_RDY  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      rd_mode_q <= rd_mode_d;
      MDC       <= mdc_d;
      MDIO_OUT  <= out_d;
      MDIO_OE   <= oe_d;
      RD_DATA   <= rd_data_d;
      DATA_RDY  <= rdy_d;
      BUSY      <= busy_d;
    end
  end

endmodule

// File: tb/tb_generador_mdio.sv
// Self-checking bench for generador_mdio: one instance with a 32-bit preamble,
// one without. Expected line activity is built from the frame rules per slot.
module tb_generador_mdio;

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [2];
  logic [31:0] t_data   [2];
  logic        mdio_in  [2];
  logic        mdc      [2];
  logic        mdio_out [2];
  logic        mdio_oe  [2];
  logic [15:0] rd_data  [2];
  logic        data_rdy [2];
  logic        busy     [2];

  logic [15:0] model_rd [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  generador_mdio #(.PREAMBLE(32)) dut_p32 (
    .CLK(clk), .reset(reset), .MDIO_START(start[0]), .T_DATA(t_data[0]),
    .MDIO_IN(mdio_in[0]), .MDC(mdc[0]), .MDIO_OUT(mdio_out[0]), .MDIO_OE(mdio_oe[0]),
    .RD_DATA(rd_data[0]), .DATA_RDY(data_rdy[0]), .BUSY(busy[0])
  );

  generador_mdio #(.PREAMBLE(0)) dut_p0 (
    .CLK(clk), .reset(reset), .MDIO_START(start[1]), .T_DATA(t_data[1]),
    .MDIO_IN(mdio_in[1]), .MDC(mdc[1]), .MDIO_OUT(mdio_out[1]), .MDIO_OE(mdio_oe[1]),
    .RD_DATA(rd_data[1]), .DATA_RDY(data_rdy[1]), .BUSY(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input bit u);
    check("rst_mdc",     32'(mdc[u]),      32'h0);
    check("rst_out",     32'(mdio_out[u]), 32'h0);
    check("rst_oe",      32'(mdio_oe[u]),  32'h0);
    check("rst_rd_data", 32'(rd_data[u]),  32'h0);
    check("rst_rdy",     32'(data_rdy[u]), 32'h0);
    check("rst_busy",    32'(busy[u]),     32'h0);
  endtask

  // One transaction on instance u. inject: extra STARTs mid-preamble and in the DONE cycle.
  // hold: leave START high afterwards and swap T_DATA to hold_next while busy.
  task automatic run_txn(input bit u, input logic [31:0] f, input logic [15:0] phy,
                         input bit inject, input bit hold, input logic [31:0] hold_next);
    int  pre, n, s, j, rdy_cyc, slots_bad, mdc_bad, glitch_bad, busy_bad, extra;
    bit  rd, exp_mdc, prev_out, prev_oe;
    bit  exp_out [96];
    bit  exp_oe  [96];
    pre = u ? 0 : 32;
    n   = pre + 32;
    rd  = (f[29:28] == 2'b10);
    for (int i = 0; i < n; i++) begin
      if (i < pre) begin
        exp_out[i] = 1'b1;
        exp_oe[i]  = 1'b1;
      end else begin
        j          = 31 - (i - pre);
        exp_oe[i]  = !rd || (j >= 18);
        exp_out[i] = exp_oe[i] & f[5'(j)];
      end
    end
    slots_bad = 0; mdc_bad = 0; glitch_bad = 0; busy_bad = 0; extra = 0; rdy_cyc = -1;

    start[u]  = 1'b1;
    t_data[u] = f;
    @(posedge clk); #1;
    if (hold) t_data[u] = hold_next;
    else      start[u]  = 1'b0;
    check("busy_rise", 32'(busy[u]), 32'h1);
    prev_out = mdio_out[u];
    prev_oe  = mdio_oe[u];

    for (int cyc = 1; cyc <= 300 && rdy_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      if (inject && cyc == 10) begin start[u] = 1'b1; t_data[u] = ~f; end
      if (inject && cyc == 11) begin start[u] = 1'b0; t_data[u] = f;  end
      if (data_rdy[u]) begin
        rdy_cyc = cyc;
      end else begin
        exp_mdc = (cyc % 2 == 0) && (cyc >= 2) && (cyc <= 2 * n);
        if (mdc[u] !== exp_mdc) mdc_bad++;
        if (busy[u] !== 1'b1) busy_bad++;
        if (mdc[u] && (mdio_out[u] !== prev_out || mdio_oe[u] !== prev_oe)) glitch_bad++;
        if (exp_mdc) begin
          s = (cyc - 2) / 2;
          if (mdio_out[u] !== exp_out[s] || mdio_oe[u] !== exp_oe[s]) slots_bad++;
          j = 31 - (s - pre);
          // PHY answer for the data bits; noise elsewhere must never be captured.
          if (rd && s >= pre && j <= 15) mdio_in[u] = phy[4'(j)];
          else                           mdio_in[u] = 1'($urandom);
        end
      end
      prev_out = mdio_out[u];
      prev_oe  = mdio_oe[u];
    end

    check("rdy_cycle",    32'(rdy_cyc),    32'(2 * n + 1));
    check("mdc_pattern",  32'(mdc_bad),    32'h0);
    check("slot_bits",    32'(slots_bad),  32'h0);
    check("stable_on_rise", 32'(glitch_bad), 32'h0);
    check("busy_held",    32'(busy_bad),   32'h0);
    if (rdy_cyc >= 0) begin
      check("done_busy", 32'(busy[u]),    32'h1);
      check("done_oe",   32'(mdio_oe[u]), 32'h0);
      check("done_mdc",  32'(mdc[u]),     32'h0);
    end
    if (rd) model_rd[u] = phy;
    check("rd_data", 32'(rd_data[u]), 32'(model_rd[u]));

    if (inject) begin start[u] = 1'b1; t_data[u] = ~f; end
    @(posedge clk); #1;
    if (inject) start[u] = 1'b0;
    check("rdy_pulse_end", 32'(data_rdy[u]), 32'h0);
    check("busy_fall",     32'(busy[u]),     32'h0);
    if (inject) begin
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (busy[u] || data_rdy[u]) extra++;
      end
      check("no_second_txn", 32'(extra), 32'h0);
    end
    mdio_in[u] = 1'b0;
  endtask

  logic [31:0] wr_frame, rd_frame, op11_frame, f;
  int          stray;

  initial begin
    wr_frame   = {2'b01, 2'b01, 5'h03, 5'h0A, 2'b10, 16'hBEEF};
    rd_frame   = {2'b01, 2'b10, 5'h03, 5'h0A, 2'b10, 16'h6B2D};
    op11_frame = {2'b01, 2'b11, 5'h03, 5'h0A, 2'b10, 16'hBEEF};
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; t_data[i] = 32'h0; mdio_in[i] = 1'b0; model_rd[i] = 16'h0;
    end
    #12;
    check_reset_values(1'b0);
    check_reset_values(1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Write with preamble, then read, then START pulses while busy.
    run_txn(1'b0, wr_frame, 16'h0000, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, rd_frame, 16'hA5C3, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, 32'h5A5A_1234, 16'h0000, 1'b1, 1'b0, 32'h0);

    // Reset during the high phase of frame bit 20 of a read.
    start[0] = 1'b1; t_data[0] = rd_frame;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (88) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_reset_values(1'b0);
    model_rd[0] = 16'h0;
    model_rd[1] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 140; i++) begin
      @(posedge clk); #1;
      if (data_rdy[0] || busy[0]) stray++;
    end
    check("no_rdy_after_reset", 32'(stray), 32'h0);
    run_txn(1'b0, rd_frame, 16'h3C5A, 1'b0, 1'b0, 32'h0);

    // Back-to-back on the no-preamble instance with START held high.
    run_txn(1'b1, wr_frame, 16'h0000, 1'b0, 1'b1, rd_frame);
    run_txn(1'b1, rd_frame, 16'h1234, 1'b0, 1'b0, 32'h0);

    // OP=11 behaves as a write.
    run_txn(1'b0, op11_frame, 16'h0000, 1'b0, 1'b0, 32'h0);

    // Random frames on both instances, reads biased to be frequent.
    for (int i = 0; i < 8; i++) begin
      f = $urandom;
      if ($urandom_range(1, 0) == 1) f[29:28] = 2'b10;
      run_txn(1'(i), f, 16'($urandom), 1'b0, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generador_mdio.md
# generador_mdio

MDIO management-side transmitter (station management, STA) that pairs with the team's MDIO receiver on the PHY side. From a single system clock it generates MDC, serializes a preamble plus a 32-bit management frame onto MDIO, and releases the line during the turnaround and data phases of read frames. It also captures the 16 returned data bits and presents them on `RD_DATA` with a one-cycle `DATA_RDY` pulse.

## Interface

Parameters:
- `PREAMBLE`, default 32: number of preamble '1' bits sent before the frame. Legal range 0..63.

Ports:
- `CLK` input 1: system clock, the only clock. MDC is derived from it.
- `reset` input 1: asynchronous, active-low reset.
- `MDIO_START` input 1: start request, sampled only in IDLE.
- `T_DATA` input [31:0]: frame, captured on the cycle START is accepted.
  - [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data.
- `MDIO_IN` input 1: serial data returned by the PHY during reads.
- `MDC` output 1: management clock, CLK/2, active only during a transaction.
- `MDIO_OUT` output 1: serial data to the PHY.
- `MDIO_OE` output 1: output enable for `MDIO_OUT`. 1 means the STA drives the line.
- `RD_DATA` output [15:0]: read data, MSB first as received.
- `DATA_RDY` output 1: one-cycle pulse at transaction end.
- `BUSY` output 1: high from START acceptance through the `DATA_RDY` cycle.

## Operation

- States are IDLE, PRE, FRAME and DONE.
- **Reset (async, reset=0):** state=IDLE; `MDC`=0; `MDIO_OUT`=0; `MDIO_OE`=0; `RD_DATA`=16'h0000; `DATA_RDY`=0; `BUSY`=0; bit counter and phase flag cleared.
- **IDLE:**
  - `MDC`=0 and `MDIO_OE`=0.
  - On `MDIO_START`=1, latch `T_DATA`, set `BUSY`, and go to PRE (or straight to FRAME when PREAMBLE=0).
  - Read mode is latched when OP=2'b10. Every other OP value, including 00 and 11, is handled as a write.
- **Bit slot:** each bit takes 2 CLK cycles.
  - Low phase: `MDC`=0 and the new `MDIO_OUT` value is presented.
  - High phase: `MDC`=1. The PHY samples on the MDC rising edge.
- **PRE:**
  - Send PREAMBLE slots with `MDIO_OUT`=1 and `MDIO_OE`=1, then go to FRAME.
- **FRAME:** send bits 31 down to 0, MSB first.
  - Write: `MDIO_OE`=1 for all 32 slots; `MDIO_OUT` = latched bit.
  - Read, bits 31..18 (ST/OP/PHYAD/REGAD): driven with `MDIO_OE`=1.
  - Read, bits 17..0 (TA and data): `MDIO_OE`=0 and `MDIO_OUT`=0.
  - Read capture: for bits 15..0, sample `MDIO_IN` on the CLK edge that ends the slot's high phase (the edge where MDC falls) and shift it into `RD_DATA` LSB-in, so the first received bit ends up in `RD_DATA[15]`.
  - In write mode `RD_DATA` holds its previous value.
- **DONE:**
  - One cycle with `MDC`=0, `MDIO_OE`=0, `DATA_RDY`=1 and `BUSY`=1.
  - Next cycle: IDLE with `BUSY`=0.
- **START while not IDLE:** ignored. `T_DATA` changes while busy have no effect.
- **START during the DONE cycle:** ignored. A new START is accepted on the first IDLE cycle.
- **Back-to-back transactions:** minimum gap is one IDLE cycle between DONE and the next accepted START.
- **Reset mid-transaction:** immediate return to reset values. No `DATA_RDY`, and no partial `RD_DATA` is retained.

## Timing

- START accepted at CLK edge k.
- First low phase (`MDC`=0, first bit driven) is visible after edge k+1.
- First `MDC` rising edge occurs at edge k+2.
- Transaction length is 2·(PREAMBLE+32) CLK cycles. `DATA_RDY` is high in the cycle following edge k+2·(PREAMBLE+32)+1.
  - PREAMBLE=32: `DATA_RDY` after edge k+129.
  - PREAMBLE=0: `DATA_RDY` after edge k+65.
- `MDIO_OUT` and `MDIO_OE` change only on edges that drive `MDC` low, never coincident with an `MDC` rise.
- `MDC` is glitch-free and registered. Its duty cycle is exactly 50% during a transaction.
- `RD_DATA` is stable from the `DATA_RDY` cycle until the next read transaction's first capture.
- The `BUSY` rise is registered: high after edge k.

## Test plan

1. **Write:** PREAMBLE=32, `T_DATA`=32'h5_?: ST=01, OP=01, PHYAD=5'h03, REGAD=5'h0A, TA=10, data=16'hBEEF.
   - Required: 32 ones, then exactly those 32 bits sampled on `MDC` rises.
   - `MDIO_OE`=1 throughout; `DATA_RDY` one cycle after edge k+129.
   - `RD_DATA` unchanged.
2. **Read:** OP=10, PHY model returning 16'hA5C3, driving MDIO after each MDC rise.
   - Required: `MDIO_OE` falls before the TA slot (bit 17) and stays 0 through bit 0.
   - `RD_DATA`=16'hA5C3 with the `DATA_RDY` pulse.
3. **START during busy:** pulse `MDIO_START` with a different `T_DATA` mid-PRE and during DONE.
   - Required: original frame bits unchanged, a single `DATA_RDY`, and no second transaction.
4. **Reset mid-frame:** assert `reset`=0 during FRAME bit 20.
   - Required: all outputs at reset values immediately (asynchronously) and no `DATA_RDY`.
   - A fresh transaction completes correctly after release.
5. **Back-to-back with PREAMBLE=0:** a write followed by a read, START held high.
   - Required: the second frame begins one IDLE cycle after DONE.
   - Each transaction gives exactly one `DATA_RDY`, the write at edge k+65.
6. **OP=11:** required behaviour is identical to the write in scenario 1, with `MDIO_OE`=1 for all 32 frame bits.
